// File: rtl/duty_cycle_pkg.sv
// Shared constants and types for the duty-cycle measurement block.
package duty_cycle_pkg;

  // Default width of the high/period cycle counters.
  localparam int CNT_W = 16;
  // Full-scale result (100 % duty) in basis points; fits in 14 bits.
  localparam int SCALE = 10000;
  // Numerator width: high_cnt * SCALE needs CNT_W + 14 bits.
  localparam int NUM_W = CNT_W + 14;

  // Sequential divider control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } div_state_t;

endpackage : duty_cycle_pkg

// File: rtl/duty_cycle_seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// Handshake: i_start is accepted only in a cycle where o_busy is low; the
// operands are captured on that edge. o_done pulses for exactly one cycle,
// during which o_quot holds the final quotient. A zero divisor yields 0.
module seq_divider
  import duty_cycle_pkg::*;
#(
  parameter int DVD_W = NUM_W,
  parameter int DVS_W = CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [DVD_W-1:0] i_num,
  input  logic [DVS_W-1:0] i_den,
  output logic             o_busy,
  output logic             o_done,
  output logic [DVD_W-1:0] o_quot,
  output div_state_t       o_state
);

  localparam int BC_W = $clog2(DVD_W + 1);

  div_state_t       r_state;
  div_state_t       w_state_next;
  logic [DVD_W-1:0] r_quot;
  logic [DVS_W-1:0] r_den;
  logic [DVS_W-1:0] r_rem;
  logic [BC_W-1:0]  r_bit_cnt;

  logic [DVS_W:0]   w_rem_shift;
  logic [DVS_W:0]   w_rem_sub;
  logic             w_q_bit;

  // Partial-remainder step: bring down the next dividend bit, try subtract.
  assign w_rem_shift = {r_rem, r_quot[DVD_W-1]};
  assign w_rem_sub   = w_rem_shift - {1'b0, r_den};
  assign w_q_bit     = (w_rem_shift >= {1'b0, r_den});

  // Control state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: capture, clear, shift DVD_W times, report.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (i_start) w_state_next = LOAD;
      LOAD:    w_state_next = SHIFT;
      SHIFT:   if (r_bit_cnt == BC_W'(DVD_W - 1)) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: dividend shifts out of r_quot while quotient bits shift in.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_quot    <= '0;
      r_den     <= '0;
      r_rem     <= '0;
      r_bit_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_quot <= i_num;
            r_den  <= i_den;
          end
        end
        LOAD: begin
          r_rem     <= '0;
          r_bit_cnt <= '0;
        end
        SHIFT: begin
          r_rem     <= w_q_bit ? w_rem_sub[DVS_W-1:0] : w_rem_shift[DVS_W-1:0];
          r_quot    <= {r_quot[DVD_W-2:0], w_q_bit};
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy  = (r_state != IDLE);
  assign o_done  = (r_state == DONE);
  assign o_quot  = (r_den == '0) ? '0 : r_quot;
  assign o_state = r_state;

endmodule : seq_divider

// File: rtl/duty_cycle_circuit.sv
// Duty-cycle meter: synchronises ring_in, counts high and total cycles per
// input period (rise to rise) and divides them into basis points.
module duty_cycle_circuit
  import duty_cycle_pkg::div_state_t;
#(
  parameter int CNT_W       = duty_cycle_pkg::CNT_W,
  parameter int SCALE       = duty_cycle_pkg::SCALE,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ring_in,
  input  logic        enable,
  output logic [15:0] value,
  output div_state_t  dbg_div_state
);

  localparam int               NUMER_W = CNT_W + 14;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [15:0]      SCALE_V = 16'(SCALE);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic [CNT_W-1:0]       r_period_cnt;
  logic [CNT_W-1:0]       r_high_cnt;
  logic                   r_armed;
  logic                   r_pend_valid;
  logic [CNT_W-1:0]       r_pend_high;
  logic [CNT_W-1:0]       r_pend_period;

  logic                   w_s;
  logic                   w_rise;
  logic                   w_timeout;
  logic                   w_div_start;
  logic                   w_div_busy;
  logic                   w_div_done;
  logic [NUMER_W-1:0]     w_num;
  logic [NUMER_W-1:0]     w_quot;
  logic [15:0]            w_quot_clamped;

  // Synchroniser chain for the asynchronous input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], ring_in};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Edge-history flop for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s_d <= 1'b0;
    end else begin
      r_s_d <= w_s;
    end
  end

  assign w_rise = w_s & ~r_s_d;
  // Stuck input: period counter saturated with no rise; a rise takes priority.
  assign w_timeout = enable & ~w_rise & (r_period_cnt == CNT_MAX);

  // Period/high counters and the armed flag; a rise restarts a period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_armed      <= 1'b0;
    end else if (!enable) begin
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_armed      <= 1'b0;
    end else if (w_rise) begin
      // The rise cycle itself is the first (high) cycle of the new period.
      r_period_cnt <= CNT_ONE;
      r_high_cnt   <= CNT_ONE;
      r_armed      <= 1'b1;
    end else if (w_timeout) begin
      r_period_cnt <= '0;
      r_high_cnt   <= '0;
      r_armed      <= 1'b0;
    end else begin
      if (r_period_cnt != CNT_MAX) r_period_cnt <= r_period_cnt + 1'b1;
      if (w_s && (r_high_cnt != CNT_MAX)) r_high_cnt <= r_high_cnt + 1'b1;
    end
  end

  // Single-entry pending slot; a newer snapshot replaces an unconsumed one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_valid  <= 1'b0;
      r_pend_high   <= '0;
      r_pend_period <= '0;
    end else if (!enable) begin
      r_pend_valid <= 1'b0;
    end else if (w_rise && r_armed) begin
      r_pend_valid  <= 1'b1;
      r_pend_high   <= r_high_cnt;
      r_pend_period <= r_period_cnt;
    end else if (w_timeout || w_div_start) begin
      r_pend_valid <= 1'b0;
    end
  end

  assign w_div_start = enable & r_pend_valid & ~w_div_busy;
  assign w_num       = NUMER_W'(r_pend_high) * NUMER_W'(SCALE);

  seq_divider #(
    .DVD_W (NUMER_W),
    .DVS_W (CNT_W)
  ) u_div (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_start (w_div_start),
    .i_num   (w_num),
    .i_den   (r_pend_period),
    .o_busy  (w_div_busy),
    .o_done  (w_div_done),
    .o_quot  (w_quot),
    .o_state (dbg_div_state)
  );

  assign w_quot_clamped = (w_quot > NUMER_W'(SCALE)) ? SCALE_V : w_quot[15:0];

  // Result register: stuck-input verdict or a finished division.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (w_timeout) begin
      value <= w_s ? SCALE_V : 16'd0;
    end else if (w_div_done) begin
      value <= w_quot_clamped;
    end
  end

endmodule : duty_cycle_circuit

// File: tb/tb_duty_cycle_circuit.sv
// Self-checking bench for duty_cycle_circuit. A narrow counter width keeps
// the stuck-input timeout short (2^10-1 cycles).
module tb_duty_cycle_circuit;

  localparam int TB_CNT_W  = 10;
  localparam int TB_SCALE  = 10000;
  localparam int TB_SYNC   = 2;
  localparam int TMO_CYC   = (1 << TB_CNT_W) - 1;

  logic        clk;
  logic        reset;
  logic        ring_in;
  logic        enable;
  logic [15:0] value;
  duty_cycle_pkg::div_state_t dbg_div_state;

  int n_vec;
  int n_err;

  duty_cycle_circuit #(
    .CNT_W       (TB_CNT_W),
    .SCALE       (TB_SCALE),
    .SYNC_STAGES (TB_SYNC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ring_in       (ring_in),
    .enable        (enable),
    .value         (value),
    .dbg_div_state (dbg_div_state)
  );

  // Clock: 20 ns period.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Reference: duty of a square wave with h high and l low cycles.
  function automatic logic [15:0] ref_duty(input int h, input int l);
    int q;
    q = (h * TB_SCALE) / (h + l);
    if (q > TB_SCALE) q = TB_SCALE;
    return 16'(q);
  endfunction

  // Periods needed for the reading to settle after a pattern change.
  function automatic int settle_periods(input int h, input int l);
    return 3 + 60 / (h + l);
  endfunction

  task automatic check(input string tag, input logic [15:0] exp);
    n_vec++;
    assert (value === exp)
    else begin
      n_err++;
      $error("FAIL %s: value=%0d expected=%0d", tag, value, exp);
    end
  endtask

  // Drive n periods of h-high/l-low; optionally check value every cycle.
  task automatic run_wave(input int h, input int l, input int n,
                          input bit chk, input logic [15:0] exp, input string tag);
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < h; i++) begin
        ring_in = 1'b1;
        @(negedge clk);
        if (chk) check(tag, exp);
      end
      for (int i = 0; i < l; i++) begin
        ring_in = 1'b0;
        @(negedge clk);
        if (chk) check(tag, exp);
      end
    end
  endtask

  task automatic hold_input(input logic lvl, input int cycles);
    ring_in = lvl;
    repeat (cycles) @(negedge clk);
  endtask

  // Settle on a pattern, check the reading, then check it holds for 2 periods.
  task automatic measure(input int h, input int l, input string tag);
    logic [15:0] e;
    e = ref_duty(h, l);
    run_wave(h, l, settle_periods(h, l), 1'b0, e, tag);
    check(tag, e);
    run_wave(h, l, 2, 1'b1, e, tag);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b1;
    ring_in = 1'b0;
    enable  = 1'b1;

    #100;
    check("reset_value", 16'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_value", 16'd0);

    // Directed duty patterns.
    measure(1, 1, "duty50");
    measure(2, 6, "duty25");
    measure(6, 2, "duty75");
    measure(1, 2, "duty33_floor");

    // Stuck low after a valid measurement.
    hold_input(1'b0, TMO_CYC - 120);
    check("stuck0_before_tmo", ref_duty(1, 2));
    hold_input(1'b0, 240);
    check("stuck0_after_tmo", 16'd0);

    // Stuck high.
    hold_input(1'b1, TMO_CYC - 120);
    check("stuck1_before_tmo", 16'd0);
    hold_input(1'b1, 240);
    check("stuck1_after_tmo", 16'(TB_SCALE));

    // Randomised patterns against the reference.
    for (int t = 0; t < 8; t++) begin
      int h;
      int l;
      h = $urandom_range(1, 40);
      l = $urandom_range(1, 40);
      measure(h, l, $sformatf("rand_h%0d_l%0d", h, l));
    end

    // Enable low: reading holds while the input changes.
    measure(1, 3, "pre_disable");
    enable = 1'b0;
    run_wave(3, 1, 12, 1'b1, ref_duty(1, 3), "disabled_hold");
    // Re-enable: first period only arms, so no new result for a while.
    enable = 1'b1;
    run_wave(3, 1, 7, 1'b1, ref_duty(1, 3), "reenable_first_discarded");
    run_wave(3, 1, 15, 1'b0, 16'd0, "");
    check("reenable_result", ref_duty(3, 1));

    // Asynchronous reset while the divider is busy.
    measure(1, 1, "pre_reset_mid_div");
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_mid_div", 16'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("after_reset_release", 16'd0);
    measure(1, 1, "after_reset_duty50");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_duty_cycle_circuit
